// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU command sequencer:
//   - aluop encodings understood by the external combinational ALU
//   - bit positions inside the command header byte
//   - sequencer FSM state encoding
//   - helper to detect a header with reserved bits set
package alu_pkg;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   // Header layout: [1:0] aluop, [2] neg, [3] use_acc, [4] keep, [7:5] reserved
   localparam int HDR_NEG     = 2;
   localparam int HDR_USE_ACC = 3;
   localparam int HDR_KEEP    = 4;
   localparam logic [7:0] HDR_RSVD_MASK = 8'hE0;

   typedef enum logic [2:0] {
      ST_HDR   = 3'd0,
      ST_GET_A = 3'd1,
      ST_GET_B = 3'd2,
      ST_EXEC  = 3'd3,
      ST_SEND  = 3'd4
   } state_t;

   function automatic logic hdr_rsvd_set(input logic [7:0] hdr);
      return |(hdr & HDR_RSVD_MASK);
   endfunction

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Command-side front end for an external combinational 8-bit ALU. Byte-serial
// frames (header, optional A byte, B byte) arrive on a valid/ready stream; the
// header is decoded into aluop/neg, operands are registered onto alu_a/alu_b,
// the ALU result is captured one cycle later and offered on a valid/ready
// output stream. An 8-bit accumulator can stand in for operand A and/or
// receive the result, allowing chained operations.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_data/in_valid/in_ready      command byte stream
//   out_data/out_zero/out_valid/out_ready   result stream (out_zero = result==0)
//   alu_a/alu_b/alu_op/alu_neg     registered operands/controls to the ALU
//   alu_o               combinational ALU result
//   err                 one-cycle pulse when a header is rejected
//   acc                 current accumulator value
module alu_sequencer
   import alu_pkg::*;
#(
   parameter logic [7:0] ACC_INIT    = 8'h00,
   parameter bit         ERR_ON_RSVD = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_zero,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [1:0] alu_op,
   output logic       alu_neg,
   input  logic [7:0] alu_o,
   output logic       err,
   output logic [7:0] acc
);

   state_t state_q, state_d;

   // Cleared by reset and set on the first clock afterwards, so in_ready stays
   // low while rst is held and rises only after the first post-release edge.
   logic rdy_en;
   logic keep_q;

   logic hdr_take;
   logic a_take;
   logic b_take;
   logic exec_go;
   logic send_done;
   logic rsvd_rej;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_HDR;
         rdy_en  <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_en  <= 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      hdr_take  = 1'b0;
      a_take    = 1'b0;
      b_take    = 1'b0;
      exec_go   = 1'b0;
      send_done = 1'b0;
      rsvd_rej  = 1'b0;
      case (state_q)
         ST_HDR: begin
            in_ready = rdy_en;
            if (in_valid && rdy_en) begin
               if (ERR_ON_RSVD && hdr_rsvd_set(in_data)) begin
                  rsvd_rej = 1'b1;
               end else begin
                  hdr_take = 1'b1;
                  state_d  = in_data[HDR_USE_ACC] ? ST_GET_B : ST_GET_A;
               end
            end
         end
         ST_GET_A: begin
            in_ready = rdy_en;
            if (in_valid && rdy_en) begin
               a_take  = 1'b1;
               state_d = ST_GET_B;
            end
         end
         ST_GET_B: begin
            in_ready = rdy_en;
            if (in_valid && rdy_en) begin
               b_take  = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            exec_go = 1'b1;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (out_ready) begin
               send_done = 1'b1;
               state_d   = ST_HDR;
            end
         end
         default: state_d = ST_HDR;
      endcase
   end

   // Operand/result registers. ALU controls hold their values after the frame
   // so the ALU output remains stable until the next frame overwrites them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a     <= 8'h00;
         alu_b     <= 8'h00;
         alu_op    <= ALU_ADD;
         alu_neg   <= 1'b0;
         keep_q    <= 1'b0;
         out_data  <= 8'h00;
         out_zero  <= 1'b0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         acc       <= ACC_INIT;
      end else begin
         err <= rsvd_rej;
         if (hdr_take) begin
            alu_op  <= in_data[1:0];
            alu_neg <= in_data[HDR_NEG];
            keep_q  <= in_data[HDR_KEEP];
            if (in_data[HDR_USE_ACC]) begin
               alu_a <= acc;
            end
         end
         if (a_take) begin
            alu_a <= in_data;
         end
         if (b_take) begin
            alu_b <= in_data;
         end
         // use_acc together with keep is a read-modify-write: alu_a already
         // holds the old accumulator, acc takes the new result here.
         if (exec_go) begin
            out_data  <= alu_o;
            out_zero  <= (alu_o == 8'h00);
            out_valid <= 1'b1;
            if (keep_q) begin
               acc <= alu_o;
            end
         end
         if (send_done) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Bench for alu_sequencer with a behavioural model of the external ALU closing
// the loop. Table-driven frames plus hand-written sequences for backpressure,
// stalled input, reserved headers and reset in mid-frame. Expected results are
// queued when a frame is driven and popped when the DUT offers a result.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_zero;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [1:0] alu_op;
   logic       alu_neg;
   logic [7:0] alu_o;
   logic       err;
   logic [7:0] acc;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] d;
      logic       z;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [7:0] hdr;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_out;
      logic       exp_zero;
      logic [7:0] exp_acc;
   } vec_t;
   vec_t tbl[10];

   alu_sequencer #(.ACC_INIT(8'h00), .ERR_ON_RSVD(1'b1)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_zero(out_zero), .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_neg(alu_neg), .alu_o(alu_o),
      .err(err), .acc(acc)
   );

   // External ALU: add/sub/and/or, optional inversion as 8'hFF - raw.
   function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] op, input logic neg);
      logic [7:0] raw;
      case (op)
         2'b00:   raw = a + b;
         2'b01:   raw = a - b;
         2'b10:   raw = a & b;
         default: raw = a | b;
      endcase
      return neg ? (8'hFF - raw) : raw;
   endfunction

   assign alu_o = alu_model(alu_a, alu_b, alu_op, alu_neg);

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present one byte and hold it until accepted (bounded); returns #1 after
   // the accepting edge with in_valid dropped.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         check("send_byte_timeout", 32'd0, 32'd1);
      end else begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out_valid();
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
   endtask

   // Wait for a result, compare it with the queue head, then complete the transfer.
   task automatic get_result(input string name);
      exp_t e;
      wait_out_valid();
      if (out_valid) begin
         if (sb.size() == 0) begin
            check({name, "_unexpected_result"}, 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check({name, "_data"}, {24'd0, out_data}, {24'd0, e.d});
            check({name, "_zero"}, {31'd0, out_zero}, {31'd0, e.z});
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         check({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      end
   endtask

   task automatic run_frame(input logic [7:0] hdr, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] exp_out, input logic exp_zero);
      exp_t e;
      send_byte(hdr);
      if (!hdr[3]) send_byte(a);
      send_byte(b);
      e.d = exp_out;
      e.z = exp_zero;
      sb.push_back(e);
   endtask

   initial begin
      rst       = 1'b1;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b0;

      tbl[0] = '{8'h00, 8'h12, 8'h34, 8'h46, 1'b0, 8'h00};   // add
      tbl[1] = '{8'h05, 8'h05, 8'h03, 8'hFD, 1'b0, 8'h00};   // sub + neg
      tbl[2] = '{8'h01, 8'h00, 8'h01, 8'hFF, 1'b0, 8'h00};   // sub wrap
      tbl[3] = '{8'h10, 8'h10, 8'h20, 8'h30, 1'b0, 8'h30};   // add, keep
      tbl[4] = '{8'h0B, 8'h00, 8'h0F, 8'h3F, 1'b0, 8'h30};   // or, use_acc
      tbl[5] = '{8'h18, 8'h00, 8'h05, 8'h35, 1'b0, 8'h35};   // add, use_acc+keep
      tbl[6] = '{8'h1D, 8'h00, 8'h05, 8'hCF, 1'b0, 8'hCF};   // sub+neg, use_acc+keep
      tbl[7] = '{8'h07, 8'h0F, 8'hF0, 8'h00, 1'b1, 8'hCF};   // or+neg -> zero
      tbl[8] = '{8'h02, 8'hF0, 8'h0F, 8'h00, 1'b1, 8'hCF};   // and -> zero
      tbl[9] = '{8'h02, 8'h3C, 8'h0F, 8'h0C, 1'b0, 8'hCF};   // and

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'h00);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_acc", {24'd0, acc}, 32'h00);
      check("rst_alu_a", {24'd0, alu_a}, 32'h00);
      check("rst_alu_op", {30'd0, alu_op}, 32'd0);
      rst = 1'b0;
      #1;
      check("rel_in_ready_before_edge", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check("rel_in_ready_after_edge", {31'd0, in_ready}, 32'd1);

      // Table-driven frames
      for (int i = 0; i < 10; i++) begin
         run_frame(tbl[i].hdr, tbl[i].a, tbl[i].b, tbl[i].exp_out, tbl[i].exp_zero);
         check($sformatf("vec%0d_in_ready_busy", i), {31'd0, in_ready}, 32'd0);
         get_result($sformatf("vec%0d", i));
         check($sformatf("vec%0d_acc", i), {24'd0, acc}, {24'd0, tbl[i].exp_acc});
         check($sformatf("vec%0d_alu_op_hold", i), {30'd0, alu_op}, {30'd0, tbl[i].hdr[1:0]});
      end

      // Output backpressure: result held, no byte consumed
      run_frame(8'h00, 8'h01, 8'h02, 8'h03, 1'b0);
      wait_out_valid();
      in_data  = 8'h55;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("bp_data_%0d", k), {24'd0, out_data}, 32'h03);
         check($sformatf("bp_valid_%0d", k), {31'd0, out_valid}, 32'd1);
         check($sformatf("bp_in_ready_%0d", k), {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      get_result("bp");
      check("bp_back_to_hdr", {31'd0, in_ready}, 32'd1);
      run_frame(8'h00, 8'h0A, 8'h05, 8'h0F, 1'b0);
      get_result("bp_next");

      // Input stall between A and B
      send_byte(8'h00);
      send_byte(8'h20);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check($sformatf("stall_in_ready_%0d", k), {31'd0, in_ready}, 32'd1);
         check($sformatf("stall_no_out_%0d", k), {31'd0, out_valid}, 32'd0);
      end
      send_byte(8'h22);
      sb.push_back('{8'h42, 1'b0});
      get_result("stall");

      // Reserved header rejected
      send_byte(8'hE0);
      check("rsvd_err_pulse", {31'd0, err}, 32'd1);
      check("rsvd_stay_hdr", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      check("rsvd_err_clear", {31'd0, err}, 32'd0);
      run_frame(8'h02, 8'hF0, 8'h0F, 8'h00, 1'b1);
      get_result("rsvd_next");

      // Reset in mid-frame after the A byte
      run_frame(8'h10, 8'h40, 8'h01, 8'h41, 1'b0);
      get_result("pre_rst");
      check("pre_rst_acc", {24'd0, acc}, 32'h41);
      send_byte(8'h10);
      send_byte(8'h11);
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("mid_rst_acc", {24'd0, acc}, 32'h00);
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_frame(8'h00, 8'h12, 8'h34, 8'h46, 1'b0);
      get_result("post_rst");
      check("post_rst_acc", {24'd0, acc}, 32'h00);

      check("scoreboard_empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
